// File: rtl/vend_pkg.sv
// Shared types for the vending change path: coin values, legacy coin codes
// and the dispenser state encoding.
package vend_pkg;

    // Coin values in $5 units
    localparam logic [1:0] COIN_5  = 2'd1;
    localparam logic [1:0] COIN_10 = 2'd2;

    typedef enum logic [1:0] {
        CODE_NONE = 2'b00,
        CODE_5    = 2'b01,
        CODE_10   = 2'b10
    } coin_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SELECT,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAULT
    } disp_state_e;

    function automatic logic [1:0] coin_value(coin_code_e code);
        case (code)
            CODE_5:  return COIN_5;
            CODE_10: return COIN_10;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Controller/hopper-side bundle of the change dispenser.
// slave = dispenser side, master = controller/hopper side.
interface vend_change_dispenser_if #(
    parameter int CHG_W = 4,
    parameter int CNT_W = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [CHG_W-1:0] req_amount;
    logic             eject_5;
    logic             eject_10;
    logic             hopper_done;
    logic             refill_5;
    logic             refill_10;
    logic             done;
    logic             short_err;
    logic             fault;
    logic [CHG_W-1:0] paid_amount;
    logic [CNT_W-1:0] fives_cnt;
    logic [CNT_W-1:0] tens_cnt;

    modport slave (
        input  req_valid, req_amount, hopper_done, refill_5, refill_10,
        output req_ready, eject_5, eject_10, done, short_err, fault,
               paid_amount, fives_cnt, tens_cnt
    );

    modport master (
        output req_valid, req_amount, hopper_done, refill_5, refill_10,
        input  req_ready, eject_5, eject_10, done, short_err, fault,
               paid_amount, fives_cnt, tens_cnt
    );
endinterface

// File: rtl/vend_coin_inventory.sv
// Saturating $5/$10 coin inventory. Index 0 = $5, index 1 = $10.
module vend_coin_inventory #(
    parameter int CNT_W      = 8,
    parameter int INIT_FIVES = 20,
    parameter int INIT_TENS  = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refill_5_i,
    input  logic             refill_10_i,
    input  logic             dec_5_i,
    input  logic             dec_10_i,
    output logic [CNT_W-1:0] fives_cnt_o,
    output logic [CNT_W-1:0] tens_cnt_o
);

    logic [1:0]            inc;
    logic [1:0]            dec;
    logic [1:0][CNT_W-1:0] cnt;

    assign inc = {refill_10_i, refill_5_i};
    assign dec = {dec_10_i, dec_5_i};

    for (genvar g = 0; g < 2; g++) begin : g_cnt
        localparam logic [CNT_W-1:0] INIT = (g == 0) ? CNT_W'(INIT_FIVES) : CNT_W'(INIT_TENS);
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Simultaneous refill and decrement cancel out
        always_comb begin
            cnt_d = cnt_q;
            if (inc[g] && !dec[g] && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + 1'b1;
            else if (dec[g] && !inc[g] && (cnt_q != '0))
                cnt_d = cnt_q - 1'b1;
        end

        always_ff @(posedge clk) begin
            if (reset) cnt_q <= INIT;
            else       cnt_q <= cnt_d;
        end

        assign cnt[g] = cnt_q;
    end

    assign fives_cnt_o = cnt[0];
    assign tens_cnt_o  = cnt[1];

endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout FSM: feasibility check, then tens-first coin ejection with one
// hopper acknowledge per coin and a jam timeout.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int CHG_W      = 4,
    parameter int CNT_W      = 8,
    parameter int INIT_FIVES = 20,
    parameter int INIT_TENS  = 20,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    vend_change_dispenser_if.slave  bus
);

    localparam int CW    = ((CNT_W > CHG_W) ? CNT_W : CHG_W) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    disp_state_e      state_q, state_d;
    coin_code_e       coin_q, coin_d;
    logic [CHG_W-1:0] remaining_q, remaining_d;
    logic [CHG_W-1:0] paid_q, paid_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [CNT_W-1:0] fives;
    logic [CNT_W-1:0] tens;
    logic             dec_5;
    logic             dec_10;
    logic             short;
    logic [CHG_W-1:0] step;
    logic [CW-1:0]    rem_w, tens_w, half_w, take10, need5;

    vend_coin_inventory #(
        .CNT_W      (CNT_W),
        .INIT_FIVES (INIT_FIVES),
        .INIT_TENS  (INIT_TENS)
    ) u_inv (
        .clk         (clk),
        .reset       (reset),
        .refill_5_i  (bus.refill_5),
        .refill_10_i (bus.refill_10),
        .dec_5_i     (dec_5),
        .dec_10_i    (dec_10),
        .fives_cnt_o (fives),
        .tens_cnt_o  (tens)
    );

    // Greedy feasibility: use as many tens as exist, fives cover the rest
    always_comb begin
        rem_w  = CW'(remaining_q);
        tens_w = CW'(tens);
        half_w = rem_w >> 1;
        take10 = (tens_w < half_w) ? tens_w : half_w;
        need5  = rem_w - (take10 << 1);
        short  = CW'(fives) < need5;
        step   = CHG_W'(coin_value(coin_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            coin_q      <= CODE_NONE;
            remaining_q <= '0;
            paid_q      <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            coin_q      <= coin_d;
            remaining_q <= remaining_d;
            paid_q      <= paid_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        coin_d      = coin_q;
        remaining_d = remaining_q;
        paid_d      = paid_q;
        tmo_d       = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    remaining_d = bus.req_amount;
                    paid_d      = '0;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK:  state_d = short ? ST_IDLE : ST_SELECT;
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    coin_d  = ((remaining_q >= CHG_W'(2)) && (tens != '0)) ? CODE_10 : CODE_5;
                    state_d = ST_EJECT;
                end
            end
            ST_EJECT: begin
                tmo_d   = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.hopper_done) begin
                    remaining_d = remaining_q - step;
                    paid_d      = paid_q + step;
                    state_d     = ST_SELECT;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = (state_q == ST_IDLE);
        dec_5           = (state_q == ST_EJECT) && (coin_q == CODE_5);
        dec_10          = (state_q == ST_EJECT) && (coin_q == CODE_10);
        bus.eject_5     = dec_5;
        bus.eject_10    = dec_10;
        bus.done        = (state_q == ST_DONE);
        bus.short_err   = (state_q == ST_CHECK) && short;
        bus.fault       = (state_q == ST_FAULT);
        bus.paid_amount = paid_q;
        bus.fives_cnt   = fives;
        bus.tens_cnt    = tens;
    end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed table-driven bench for the change dispenser plus jam/reset sequences.
module tb_vend_change_dispenser;

    localparam int CHG_W   = 4;
    localparam int CNT_W   = 8;
    localparam int TMO     = 16;
    localparam int ACK_DLY = 2;

    logic clk = 1'b0;
    logic reset;

    vend_change_dispenser_if #(.CHG_W(CHG_W), .CNT_W(CNT_W)) bus ();

    vend_change_dispenser #(
        .CHG_W(CHG_W), .CNT_W(CNT_W), .INIT_FIVES(4), .INIT_TENS(2), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int amt;      // request amount
        int rf5;      // $5 refills before request
        int rf10;     // $10 refills before request
        int roe;      // refill_10 coincident with each eject_10
        int e10;      // expected eject_10 count
        int e5;       // expected eject_5 count
        int first;    // first coin: 1=$10, 0=$5, 2=none
        int dn;       // expected done
        int sh;       // expected short_err
        int lat;      // cycles from handshake to done/short_err
        int paid;
        int fives;
        int tens;
    } vec_t;

    vec_t vecs[8];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic refills(input int n5, input int n10);
        for (int i = 0; i < n5; i++) begin
            @(negedge clk); bus.refill_5 = 1'b1;
            @(negedge clk); bus.refill_5 = 1'b0;
        end
        for (int i = 0; i < n10; i++) begin
            @(negedge clk); bus.refill_10 = 1'b1;
            @(negedge clk); bus.refill_10 = 1'b0;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n5, n10, first, term, lat, both, acnt, gd, gs;
        string p;
        p = $sformatf("v%0d", idx);
        refills(v.rf5, v.rf10);
        @(negedge clk);
        check({p, " req_ready"}, int'(bus.req_ready), 1);
        bus.req_valid  = 1'b1;
        bus.req_amount = CHG_W'(v.amt);
        n5 = 0; n10 = 0; first = 2; term = 0; lat = 0; both = 0; acnt = 0; gd = 0; gs = 0;
        for (int c = 1; c <= 200 && term == 0; c++) begin
            @(negedge clk);
            bus.req_valid   = 1'b0;
            bus.refill_10   = 1'b0;
            bus.hopper_done = 1'b0;
            if (acnt > 0) begin
                acnt--;
                if (acnt == 0) bus.hopper_done = 1'b1;
            end
            if (bus.eject_5 && bus.eject_10) both = 1;
            if (bus.eject_10) begin
                n10++; acnt = ACK_DLY;
                if (first == 2) first = 1;
                if (v.roe != 0) bus.refill_10 = 1'b1;
            end else if (bus.eject_5) begin
                n5++; acnt = ACK_DLY;
                if (first == 2) first = 0;
            end
            if (bus.done || bus.short_err) begin
                gd = int'(bus.done); gs = int'(bus.short_err); lat = c; term = 1;
                check({p, " paid_amount"}, int'(bus.paid_amount), v.paid);
            end
        end
        check({p, " finished in bound"}, term, 1);
        check({p, " eject_10 count"}, n10, v.e10);
        check({p, " eject_5 count"}, n5, v.e5);
        check({p, " first coin"}, first, v.first);
        check({p, " both ejects"}, both, 0);
        check({p, " done"}, gd, v.dn);
        check({p, " short_err"}, gs, v.sh);
        check({p, " latency"}, lat, v.lat);
        @(negedge clk);
        check({p, " fives_cnt"}, int'(bus.fives_cnt), v.fives);
        check({p, " tens_cnt"}, int'(bus.tens_cnt), v.tens);
        check({p, " ready after"}, int'(bus.req_ready), 1);
    endtask

    task automatic wait_eject10(input string name);
        int found;
        found = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.eject_10) found = 1;
        end
        check(name, found, 1);
    endtask

    initial begin
        int ej;
        // amt rf5 rf10 roe e10 e5 first dn sh lat paid fives tens; ack 2 cycles after each eject
        vecs[0] = '{3, 0, 0, 0, 1, 1, 1, 1, 0, 11, 3, 3, 1};
        vecs[1] = '{2, 0, 0, 0, 1, 0, 1, 1, 0,  7, 2, 3, 0};
        vecs[2] = '{4, 1, 0, 0, 0, 4, 0, 1, 0, 19, 4, 0, 0};
        vecs[3] = '{5, 0, 2, 0, 0, 0, 2, 0, 1,  1, 0, 0, 2};
        vecs[4] = '{4, 0, 0, 1, 2, 0, 1, 1, 0, 11, 4, 0, 2};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 2, 1, 0,  3, 0, 0, 2};
        vecs[6] = '{1, 1, 0, 0, 0, 1, 0, 1, 0,  7, 1, 0, 2};
        vecs[7] = '{1, 0, 0, 0, 0, 0, 2, 0, 1,  1, 0, 0, 2};

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_amount = '0; bus.hopper_done = 1'b0;
        bus.refill_5 = 1'b0; bus.refill_10 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset fives_cnt", int'(bus.fives_cnt), 4);
        check("reset tens_cnt", int'(bus.tens_cnt), 2);
        check("reset req_ready", int'(bus.req_ready), 1);
        check("reset ejects", int'(bus.eject_5 | bus.eject_10), 0);
        check("reset fault", int'(bus.fault), 0);
        check("reset paid", int'(bus.paid_amount), 0);
        check("reset pulses", int'(bus.done | bus.short_err), 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Jam: no hopper_done after the first eject (fives 0, tens 2 here)
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_amount = CHG_W'(2);
        wait_eject10("jam first eject");
        repeat (TMO) @(negedge clk);
        check("jam fault before timeout", int'(bus.fault), 0);
        @(negedge clk);
        check("jam fault at timeout", int'(bus.fault), 1);
        check("jam req_ready", int'(bus.req_ready), 0);
        ej = 0;
        bus.req_valid = 1'b1; bus.req_amount = CHG_W'(1);
        repeat (5) begin
            @(negedge clk);
            if (bus.eject_5 || bus.eject_10) ej++;
        end
        bus.req_valid = 1'b0;
        check("jam ignores req", ej, 0);
        check("jam fault sticky", int'(bus.fault), 1);
        check("jam tens_cnt", int'(bus.tens_cnt), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset fault", int'(bus.fault), 0);
        check("post-reset ready", int'(bus.req_ready), 1);
        check("post-reset fives", int'(bus.fives_cnt), 4);
        check("post-reset tens", int'(bus.tens_cnt), 2);

        // Reset in the middle of a payout aborts it
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_amount = CHG_W'(4);
        wait_eject10("abort first eject");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ej = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.hopper_done = (c % 2 == 0);
            if (bus.eject_5 || bus.eject_10) ej++;
        end
        bus.hopper_done = 1'b0;
        check("abort no ejects", ej, 0);
        check("abort ready", int'(bus.req_ready), 1);
        check("abort tens", int'(bus.tens_cnt), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Payout end of the vending change path. The vending controller issues a change amount in $5 units; this block drives the coin hopper, one coin per handshake.
- Pays tens first, then fives, from internal coin inventory counters.
- Feasibility is checked before any coin leaves, so a payout is all-or-nothing.
- Detects hopper jams with an acknowledge timeout.

Parameters:
- CHG_W, 4: width of change amount, in $5 units.
- CNT_W, 8: width of each coin inventory counter.
- INIT_FIVES, 20: $5 coin count loaded at reset.
- INIT_TENS, 20: $10 coin count loaded at reset.
- TIMEOUT, 255: cycles to wait for hopper_done before declaring a jam.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  change request valid.
- req_ready  out  1  block can accept a request.
- req_amount  in  CHG_W  change owed, in $5 units.
- eject_5  out  1  one-cycle pulse: hopper drops one $5 coin.
- eject_10  out  1  one-cycle pulse: hopper drops one $10 coin.
- hopper_done  in  1  hopper acknowledges that the last coin dropped.
- refill_5  in  1  add one $5 coin to inventory.
- refill_10  in  1  add one $10 coin to inventory.
- done  out  1  one-cycle pulse: payout complete.
- short_err  out  1  one-cycle pulse: request rejected, inventory insufficient.
- fault  out  1  sticky jam indicator.
- paid_amount  out  CHG_W  $5 units paid so far in the current/last payout.
- fives_cnt  out  CNT_W  current $5 inventory.
- tens_cnt  out  CNT_W  current $10 inventory.

Behaviour:
- Reset: the block enters IDLE.
  - All pulses are 0, fault=0, paid_amount=0.
  - fives_cnt=INIT_FIVES, tens_cnt=INIT_TENS.
  - req_ready=1 from the first cycle after reset.
  - Reset mid-payout aborts immediately; no further eject pulses.
- req_ready = (state==IDLE). It is decoded from state only, never from req_valid.
- FSM states: IDLE, CHECK, SELECT, EJECT, WAIT_ACK, DONE, FAULT.
- IDLE:
  - On req_valid&&req_ready: latch remaining=req_amount, clear paid_amount, go to CHECK.
- CHECK (1 cycle):
  - Compute t=min(tens_cnt, remaining>>1) and need5=remaining-2*t, at max(CNT_W,CHG_W)+1 bits.
  - If fives_cnt<need5: pulse short_err, return to IDLE. Inventory is untouched.
  - Else go to SELECT.
- SELECT:
  - remaining==0: go to DONE.
  - remaining>=2 && tens_cnt>0: coin=10, go to EJECT.
  - Otherwise: coin=5, go to EJECT.
- EJECT (1 cycle):
  - Assert the matching eject pulse and decrement the matching counter.
  - Clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK:
  - On hopper_done: remaining -= 1 or 2; paid_amount += 1 or 2; go to SELECT.
  - If TIMEOUT cycles elapse without hopper_done: go to FAULT.
- DONE: pulse done for 1 cycle, go to IDLE.
  - Latency for amount 0: handshake cycle N, done at N+3 (CHECK, SELECT, DONE).
- FAULT:
  - fault=1, req_ready=0.
  - Only reset exits this state.
  - Refill still counts.
- Inventory:
  - refill_x increments the matching counter, saturating at 2^CNT_W-1.
  - Refill and decrement of the same counter in one cycle leave it unchanged.
  - A decrement never underflows; CHECK guarantees this.
- hopper_done outside WAIT_ACK is ignored.
- req_valid outside IDLE is ignored; it is not queued.
- eject_5 and eject_10 are never asserted together.
- Each eject pulse is followed by exactly one ack wait.

Decomposition:
- Shared package vend_pkg holds:
  - The coin value constants (COIN_5=1, COIN_10=2 in $5 units).
  - The dispenser state enum.
  - The legacy 2-bit coin/change codes (00 none, 01 $5, 10 $10).
- One sub-module: vend_coin_inventory. It holds both saturating counters, with refill, decrement-enable and INIT parameters.

Test Plan:
- Reset with INIT_FIVES=4, INIT_TENS=2 -> fives_cnt=4, tens_cnt=2, req_ready=1, no eject pulses, fault=0.
- req_amount=3, hopper_done 2 cycles after each eject -> eject_10 then eject_5, done pulse, paid_amount=3, tens_cnt=1, fives_cnt=3.
- tens_cnt=0, fives_cnt=4, req_amount=4 -> four eject_5 pulses, done, fives_cnt=0.
- fives_cnt=0, tens_cnt=2, req_amount=5 -> short_err pulse 1 cycle after handshake, no ejects, counts unchanged, req_ready=1.
- Withhold hopper_done after the first eject -> fault=1 after TIMEOUT cycles, req_ready=0; an asserted req_valid is ignored; reset clears fault.
- refill_10 coincident with eject_10 -> tens_cnt unchanged; req_amount=0 -> done 3 cycles after handshake with no eject.
